mux_4to1_rr_feeder: RTL



---
 rtl/mux_4to1_rr_feeder_if.sv | 40 ++++
 rtl/mux_4to1_rr_feeder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mux_4to1_rr_feeder_if.sv
// rtl/mux_4to1_rr_feeder_if.sv - handshake bundle for the 4-channel round-robin feeder
// Optional last-bit signals are present only when MUX_FEEDER_LOCK_EN is defined.
interface mux_4to1_rr_feeder_if #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2
);
    logic [3:0]           in_valid;
    logic [3:0]           in_ready;
    logic [WIDTH-1:0]     in_data0;
    logic [WIDTH-1:0]     in_data1;
    logic [WIDTH-1:0]     in_data2;
    logic [WIDTH-1:0]     in_data3;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_WIDTH-1:0] out_sel;
    logic                 busy;
`ifdef MUX_FEEDER_LOCK_EN
    logic [3:0]           in_last;
    logic                 out_last;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last, busy
    );
    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last, busy
    );
`else
    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_sel, busy
    );
    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_sel, busy
    );
`endif
endinterface

// File: rtl/mux_4to1_rr_feeder.sv
// rtl/mux_4to1_rr_feeder.sv - one-word-per-channel buffers with round-robin grant into a registered output
// MUX_FEEDER_LOCK_EN adds last-bit tracking that holds the grant on one channel until its last word.
module mux_4to1_rr_feeder #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_4to1_rr_feeder_if.slave   bus
);
    localparam int NCH = 4;

    logic [NCH-1:0]       buf_vld;
    logic [WIDTH-1:0]     buf_data [NCH];
    logic [WIDTH-1:0]     in_data  [NCH];
    logic [SEL_WIDTH-1:0] ptr;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [SEL_WIDTH-1:0] out_sel_q;
    logic [NCH-1:0]       elig;
    logic [SEL_WIDTH-1:0] win;
    logic [SEL_WIDTH-1:0] idx;
    logic                 grant;
    logic                 ld;
    logic                 take;

    assign in_data[0] = bus.in_data0;
    assign in_data[1] = bus.in_data1;
    assign in_data[2] = bus.in_data2;
    assign in_data[3] = bus.in_data3;

`ifdef MUX_FEEDER_LOCK_EN
    logic [NCH-1:0]       buf_last;
    logic                 locked;
    logic [SEL_WIDTH-1:0] lock_ch;
    logic                 out_last_q;

    // While a packet is open only its channel may win.
    assign elig = locked ? (buf_vld & (4'b0001 << lock_ch)) : buf_vld;
`else
    assign elig = buf_vld;
`endif

    always_comb begin
        grant = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr + SEL_WIDTH'(k);
            if (!grant && elig[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
    end

    assign ld   = !out_valid_q || bus.out_ready;
    assign take = ld && grant;

    // A granted buffer is cleared; in_ready was low for it, so no reload collides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= '0;
            for (int i = 0; i < NCH; i++) begin
                buf_data[i] <= '0;
            end
`ifdef MUX_FEEDER_LOCK_EN
            buf_last <= '0;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (take && win == SEL_WIDTH'(i)) begin
                    buf_vld[i] <= 1'b0;
                end else if (bus.in_valid[i] && !buf_vld[i]) begin
                    buf_vld[i]  <= 1'b1;
                    buf_data[i] <= in_data[i];
`ifdef MUX_FEEDER_LOCK_EN
                    buf_last[i] <= bus.in_last[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef MUX_FEEDER_LOCK_EN
            out_last_q  <= 1'b0;
`endif
        end else if (ld) begin
            if (grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= buf_data[win];
                out_sel_q   <= win;
`ifdef MUX_FEEDER_LOCK_EN
                out_last_q  <= buf_last[win];
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef MUX_FEEDER_LOCK_EN
    // ptr freezes for the duration of a locked packet and resumes after its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (take) begin
            if (locked) begin
                if (buf_last[win]) begin
                    locked <= 1'b0;
                    ptr    <= lock_ch + SEL_WIDTH'(1);
                end
            end else if (!buf_last[win]) begin
                locked  <= 1'b1;
                lock_ch <= win;
            end else begin
                ptr <= win + SEL_WIDTH'(1);
            end
        end
    end

    assign bus.out_last = out_last_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= win + SEL_WIDTH'(1);
        end
    end
`endif

    assign bus.in_ready  = ~buf_vld;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.busy      = (|buf_vld) || out_valid_q;
endmodule
